// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_pipe
//  Description : Three-stage pipelined floating-point adder/subtractor
//                (align, add, normalise/round), valid/ready with full stall.
//                Optional exception flags port when FP_EXC_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef FP_EXC_FLAGS_EN
    output logic [3:0]   flags,
`endif
    output logic [W-1:0] result
);

    localparam int MW  = MAN_W + 4;
    localparam int EW2 = EXP_W + 2;
    localparam int LZW = $clog2(MW + 1);

    localparam logic [1:0]       c_cls_num  = 2'd0;
    localparam logic [1:0]       c_cls_nan  = 2'd1;
    localparam logic [1:0]       c_cls_inf  = 2'd2;
    localparam logic [EXP_W-1:0] c_exp_ones = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] c_fold     = EXP_W'(MAN_W + 3);
    localparam logic [EW2-1:0]   c_exp_max  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]     c_qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic w_stall;
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // ------------------------------------------------------------------ align
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb, w_fa_f, w_fb_f;
    logic             w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

    assign w_sa = a[W-1];
    assign w_sb = b[W-1] ^ op;
    assign w_ea = a[W-2:MAN_W];
    assign w_eb = b[W-2:MAN_W];
    assign w_fa = a[MAN_W-1:0];
    assign w_fb = b[MAN_W-1:0];

    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_nan  = (w_ea == c_exp_ones) & (|w_fa);
    assign w_b_nan  = (w_eb == c_exp_ones) & (|w_fb);
    assign w_a_inf  = (w_ea == c_exp_ones) & ~(|w_fa);
    assign w_b_inf  = (w_eb == c_exp_ones) & ~(|w_fb);
    assign w_fa_f   = w_a_zero ? '0 : w_fa;
    assign w_fb_f   = w_b_zero ? '0 : w_fb;

    logic             w_swap;
    logic [EXP_W-1:0] w_e_big, w_e_sml, w_diff;
    logic [MAN_W:0]   w_m_big, w_m_sml;
    logic [MW-1:0]    w_sml_field, w_shifted, w_sml_al;
    logic             w_lost;

    assign w_swap      = {w_eb, w_fb_f} > {w_ea, w_fa_f};
    assign w_e_big     = w_swap ? w_eb : w_ea;
    assign w_e_sml     = w_swap ? w_ea : w_eb;
    assign w_m_big     = w_swap ? {~w_b_zero, w_fb_f} : {~w_a_zero, w_fa_f};
    assign w_m_sml     = w_swap ? {~w_a_zero, w_fa_f} : {~w_b_zero, w_fb_f};
    assign w_diff      = w_e_big - w_e_sml;
    assign w_sml_field = {w_m_sml, 3'b000};
    assign w_shifted   = w_sml_field >> w_diff;
    assign w_lost      = |(w_sml_field & ~({MW{1'b1}} << w_diff));
    assign w_sml_al    = (w_diff >= c_fold) ? {{(MW-1){1'b0}}, |w_m_sml}
                                            : {w_shifted[MW-1:1], w_shifted[0] | w_lost};

    logic [1:0] w_cls;
    logic       w_sign;
    always_comb begin
        w_cls = c_cls_num;
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb)))
            w_cls = c_cls_nan;
        else if (w_a_inf | w_b_inf)
            w_cls = c_cls_inf;
        w_sign = w_a_inf ? w_sa : (w_b_inf ? w_sb : (w_swap ? w_sb : w_sa));
    end

    logic             r1_valid, r1_sign, r1_zsign, r1_sub;
    logic [1:0]       r1_cls;
    logic [EXP_W-1:0] r1_exp;
    logic [MW-1:0]    r1_mbig, r1_msml;

    // -------------------------------------------------------------------- add
    logic [MW:0] w_sum;
    assign w_sum = r1_sub ? ({1'b0, r1_mbig} - {1'b0, r1_msml})
                          : ({1'b0, r1_mbig} + {1'b0, r1_msml});

    logic             r2_valid, r2_sign, r2_zsign;
    logic [1:0]       r2_cls;
    logic [EXP_W-1:0] r2_exp;
    logic [MW:0]      r2_sum;

    // ------------------------------------------------------ normalise / round
    function automatic logic [LZW-1:0] f_lzc(input logic [MW-1:0] v);
        f_lzc = LZW'(MW);
        for (int i = 0; i < MW; i++)
            if (v[i]) f_lzc = LZW'(MW - 1 - i);
    endfunction

    logic           w_carry, w_zero, w_rnd_up, w_rcarry, w_flush, w_ovf;
    logic [LZW-1:0] w_lz;
    logic [MW-1:0]  w_norm;
    logic [MAN_W:0] w_rsum;
    logic [EW2-1:0] w_exp_ext, w_lz_ext, w_expn, w_expr;

    assign w_carry   = r2_sum[MW];
    assign w_lz      = f_lzc(r2_sum[MW-1:0]);
    assign w_norm    = w_carry ? {r2_sum[MW:2], |r2_sum[1:0]} : (r2_sum[MW-1:0] << w_lz);
    // a normalised nonzero sum always carries its hidden bit at the top
    assign w_zero    = ~w_norm[MW-1];
    assign w_exp_ext = {2'b00, r2_exp};
    assign w_lz_ext  = {{(EW2-LZW){1'b0}}, w_lz};
    assign w_expn    = w_carry ? (w_exp_ext + EW2'(1)) : (w_exp_ext - w_lz_ext);
    assign w_rnd_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_rsum    = {1'b0, w_norm[MW-2:3]} + {{MAN_W{1'b0}}, w_rnd_up};
    assign w_rcarry  = w_rsum[MAN_W];
    assign w_expr    = w_expn + {{(EW2-1){1'b0}}, w_rcarry};
    assign w_flush   = w_expn[EW2-1] | (w_expn == '0);
    assign w_ovf     = (w_expr >= c_exp_max);

    logic [W-1:0] w_result;
    always_comb begin
        w_result = '0;
        case (r2_cls)
            c_cls_nan: w_result = c_qnan;
            c_cls_inf: w_result = {r2_sign, c_exp_ones, {MAN_W{1'b0}}};
            default: begin
                if (w_zero)
                    w_result = {r2_zsign, {(W-1){1'b0}}};
                else if (w_flush)
                    w_result = {r2_sign, {(W-1){1'b0}}};
                else if (w_ovf)
                    w_result = {r2_sign, c_exp_ones, {MAN_W{1'b0}}};
                else
                    w_result = {r2_sign, w_expr[EXP_W-1:0], w_rsum[MAN_W-1:0]};
            end
        endcase
    end

`ifdef FP_EXC_FLAGS_EN
    logic w_inv, r1_inv, r2_inv;
    logic w_num;
    logic [3:0] w_flags;
    // signalling NaNs have the fraction MSB clear
    assign w_inv = (w_a_nan & ~w_fa[MAN_W-1]) | (w_b_nan & ~w_fb[MAN_W-1])
                 | (w_a_inf & w_b_inf & (w_sa != w_sb));
    assign w_num = (r2_cls == c_cls_num) & ~w_zero;
    assign w_flags = {r2_inv,
                      w_num & ~w_flush & w_ovf,
                      w_num & w_flush,
                      w_num & (w_flush | w_ovf | (|w_norm[2:0]))};

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r1_inv <= w_inv;
            r2_inv <= r1_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            flags <= 4'd0;
        else if (!w_stall && r2_valid)
            flags <= w_flags;
    end
`endif

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r1_cls   <= w_cls;
            r1_sign  <= w_sign;
            r1_zsign <= w_sa & w_sb;
            r1_sub   <= (w_sa != w_sb);
            r1_exp   <= w_e_big;
            r1_mbig  <= {w_m_big, 3'b000};
            r1_msml  <= w_sml_al;
            r2_cls   <= r1_cls;
            r2_sign  <= r1_sign;
            r2_zsign <= r1_zsign;
            r2_exp   <= r1_exp;
            r2_sum   <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (!w_stall) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            out_valid <= r2_valid;
            if (r2_valid)
                result <= w_result;
        end
    end

endmodule
`default_nettype wire
